// File: rtl/io_shift_ctrl_if.sv
// Parallel request/response bus plus pad-side serial signals for io_shift_ctrl.
// The controller takes the slave side; whatever drives requests and the pad model takes master.
interface io_shift_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             wr_req;
    logic             rd_req;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             done;
    logic             io_en;
    logic             io_din;
    logic             io_dout;

    modport slave (
        input  wr_req, rd_req, wr_data, io_dout,
        output rd_data, busy, done, io_en, io_din
    );

    modport master (
        output wr_req, rd_req, wr_data, io_dout,
        input  rd_data, busy, done, io_en, io_din
    );
endinterface

// File: rtl/io_shift_ctrl.sv
// Serial pad controller: MSB-first write/read of WIDTH-bit words through a bidirectional pad.
// done fires WIDTH+1 edges after acceptance; requests are ignored while busy (no queuing).
module io_shift_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    io_shift_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_TX, S_RX, S_TURN} state_t;

    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_is_rd;
    logic             r_en;
    logic             r_din;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_is_rd   <= 1'b0;
            r_en      <= 1'b0;
            r_din     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.wr_req) begin
                        r_shreg <= bus.wr_data;
                        r_en    <= 1'b1;
                        r_din   <= bus.wr_data[WIDTH-1];
                        r_busy  <= 1'b1;
                        r_cnt   <= CW'(1);
                        r_is_rd <= 1'b0;
                        r_state <= S_TX;
                    end else if (bus.rd_req) begin
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_is_rd <= 1'b1;
                        r_state <= S_RX;
                    end
                end
                S_TX: begin
                    // Shifting the captured word left keeps the next bit at a fixed index.
                    if (r_cnt < CNT_FULL) begin
                        r_din   <= r_shreg[WIDTH-2];
                        r_shreg <= r_shreg << 1;
                        r_cnt   <= r_cnt + CW'(1);
                    end else begin
                        r_en    <= 1'b0;
                        r_din   <= 1'b0;
                        r_state <= S_TURN;
                    end
                end
                S_RX: begin
                    r_shreg <= {r_shreg[WIDTH-2:0], bus.io_dout};
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_TURN;
                    end
                end
                S_TURN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                    if (r_is_rd) begin
                        r_rd_data <= r_shreg;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_data = r_rd_data;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.io_en   = r_en;
    assign bus.io_din  = r_din;
endmodule

// File: tb/tb_io_shift_ctrl.sv
// Directed bench for io_shift_ctrl: a transaction-offset model predicts every output each cycle,
// and per-test literal checks pin stream contents, done latency and turnaround gap.
module tb_io_shift_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_shift_ctrl_if #(.WIDTH(W)) bus ();

    io_shift_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an accepted op at edge s fixes every output at offset d = edge - s.
    int          n_edge  = 0;
    int          m_op    = 0;   // 0 none, 1 write, 2 read
    int          m_start = 0;
    logic [7:0]  m_data  = '0;
    logic [7:0]  m_acc   = '0;
    logic [7:0]  m_rd    = '0;

    initial forever begin
        int d;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_op = 0; m_start = 0; n_edge = 0; m_acc = '0; m_rd = '0;
        end else begin
            n_edge++;
            d = n_edge - m_start;
            if (m_op == 2 && d >= 1 && d <= W) m_acc = {m_acc[6:0], bus.io_dout};
            if (m_op == 0 || d >= W + 2) begin
                if (bus.wr_req) begin
                    m_op = 1; m_start = n_edge; m_data = bus.wr_data;
                end else if (bus.rd_req) begin
                    m_op = 2; m_start = n_edge; m_acc = '0;
                end
            end
            d = n_edge - m_start;
            if (m_op == 2 && d == W + 1) m_rd = m_acc;
        end
    end

    logic        chk_on   = 1'b0;
    logic [31:0] ser      = '0;
    int          done_cnt = 0;
    int          low_run  = 0;
    int          last_gap = 0;
    logic        seen_en  = 1'b0;

    initial forever begin
        int d;
        logic e_en, e_din, e_busy, e_done;
        logic [7:0] sh;
        @(negedge clk);
        d = n_edge - m_start;
        e_en = 0; e_din = 0; e_busy = 0; e_done = 0;
        if (m_op != 0) begin
            e_busy = (d <= W);
            e_done = (d == W + 1);
            if (m_op == 1 && d <= W - 1) begin
                sh    = m_data << d;
                e_en  = 1'b1;
                e_din = sh[7];
            end
        end
        if (chk_on) begin
            chk("io_en",   {31'd0, bus.io_en},  {31'd0, e_en});
            chk("io_din",  {31'd0, bus.io_din}, {31'd0, e_din});
            chk("busy",    {31'd0, bus.busy},   {31'd0, e_busy});
            chk("done",    {31'd0, bus.done},   {31'd0, e_done});
            chk("rd_data", {24'd0, bus.rd_data}, {24'd0, m_rd});
        end
        if (bus.io_en) begin
            ser = {ser[30:0], bus.io_din};
            if (seen_en && low_run > 0) last_gap = low_run;
            seen_en = 1'b1;
            low_run = 0;
        end else begin
            low_run++;
        end
        if (bus.done) done_cnt++;
    end

    // Issues one request, deasserts it after acceptance, feeds pad bits MSB first,
    // optionally disturbs requests/wr_data mid-transfer, and times the done pulse.
    task automatic xfer(input logic wr, input logic rd, input logic [7:0] wdat,
                        input logic [7:0] pad, input logic noise,
                        output int lat, output int dn);
        int d0;
        lat = -1;
        d0  = done_cnt;
        bus.wr_req  = wr;
        bus.rd_req  = rd;
        bus.wr_data = wdat;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin bus.wr_req = 1'b0; bus.rd_req = 1'b0; end
            bus.io_dout = (i <= 8) ? pad[8-i] : 1'b0;
            if (noise && i == 3) begin bus.rd_req = 1'b1; bus.wr_data = 8'h00; end
            if (noise && i == 5) bus.rd_req = 1'b0;
            if (bus.done && lat < 0) lat = i;
        end
        dn = done_cnt - d0;
    endtask

    initial begin
        int lat, dn, d0;
        bus.wr_req = 0; bus.rd_req = 0; bus.wr_data = '0; bus.io_dout = 0;
        #1;
        chk_on = 1'b1;
        chk("rst_io_en",   {31'd0, bus.io_en}, 32'd0);
        chk("rst_busy",    {31'd0, bus.busy},  32'd0);
        chk("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        xfer(1, 0, 8'hA5, 8'h00, 0, lat, dn);
        chk("t1_stream", {24'd0, ser[7:0]}, 32'hA5);
        chk("t1_latency", lat, 10);
        chk("t1_done_cnt", dn, 1);
        chk("t1_rd_data", {24'd0, bus.rd_data}, 32'h00);

        xfer(0, 1, 8'h00, 8'h3C, 0, lat, dn);
        chk("t2_rd_data", {24'd0, bus.rd_data}, 32'h3C);
        chk("t2_latency", lat, 10);

        xfer(1, 1, 8'hFF, 8'h55, 0, lat, dn);
        chk("t3_stream", {24'd0, ser[7:0]}, 32'hFF);
        chk("t3_rd_data", {24'd0, bus.rd_data}, 32'h3C);
        chk("t3_done_cnt", dn, 1);

        xfer(1, 0, 8'h81, 8'h00, 1, lat, dn);
        chk("t4_stream", {24'd0, ser[7:0]}, 32'h81);
        chk("t4_done_cnt", dn, 1);

        d0 = done_cnt;
        bus.wr_req = 1'b1; bus.wr_data = 8'h5A;
        repeat (25) @(negedge clk);
        bus.wr_req = 1'b0;
        repeat (15) @(negedge clk);
        chk("t5_done_cnt", done_cnt - d0, 3);
        chk("t5_turn_gap", last_gap, 2);
        chk("t5_stream", {24'd0, ser[7:0]}, 32'h5A);

        bus.wr_req = 1'b1; bus.wr_data = 8'hF0;
        @(negedge clk);
        bus.wr_req = 1'b0;
        repeat (4) @(negedge clk);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_io_en",   {31'd0, bus.io_en},  32'd0);
        chk("t6_io_din",  {31'd0, bus.io_din}, 32'd0);
        chk("t6_busy",    {31'd0, bus.busy},   32'd0);
        chk("t6_rd_data", {24'd0, bus.rd_data}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("t6_no_done", done_cnt - d0, 0);
        xfer(0, 1, 8'h00, 8'hC3, 0, lat, dn);
        chk("t6_read", {24'd0, bus.rd_data}, 32'hC3);
        chk("t6_latency", lat, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
